// File: rtl/l3_cache_port_arbiter.sv
// l3_cache_port_arbiter: round-robin sharing of the single L3 CPU-side port
// among NUM_REQ requesters (KAN cores on the low indices, TDA engines above).
// Each transaction walks IDLE -> ISSUE -> WAIT -> RESP; only one is ever in
// flight. A WAIT timeout turns a stalled cache into an error response.
module l3_cache_port_arbiter #(
  parameter int NUM_REQ    = 20,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int TIMEOUT    = 1023,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_hit,
  output logic                            rsp_err,
  output logic [ADDR_WIDTH-1:0]           cache_addr,
  output logic [DATA_WIDTH-1:0]           cache_wdata,
  output logic                            cache_we,
  output logic                            cache_re,
  input  logic [DATA_WIDTH-1:0]           cache_rdata,
  input  logic                            cache_ready,
  input  logic                            cache_hit,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            busy,
  output logic [15:0]                     err_count
);

  // Timeout counter only needs to reach TIMEOUT-1; the abort fires when the
  // TIMEOUT-th WAIT cycle passes without cache_ready.
  localparam int              CNT_W        = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_REQ     = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [ID_W-1:0]       grant_reg, grant_next;
  logic [ID_W-1:0]       last_grant_reg, last_grant_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                  hit_reg, hit_next;
  logic                  err_reg, err_next;
  logic [15:0]           err_count_reg, err_count_next;

  // Per-requester views of the packed request buses.
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  // Round-robin selection: requesters strictly above last_grant win first;
  // if none of those are asking, the search wraps to the lowest index.
  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] masked_req;
  logic [NUM_REQ-1:0] pick_vec;
  logic [ID_W-1:0]    win_id;
  logic               any_req;
  logic               accept;
  logic               respond;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]   = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi]  = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign upper_mask[gi] = (ID_W'(gi) > last_grant_reg);
      assign req_ready[gi]  = accept && (win_id == ID_W'(gi));
      assign rsp_valid[gi]  = respond && (grant_reg == ID_W'(gi));
    end
  endgenerate

  assign any_req    = |req_valid;
  assign masked_req = req_valid & upper_mask;
  assign pick_vec   = (|masked_req) ? masked_req : req_valid;

  // Lowest set bit of pick_vec is the winner (scan downward so the lowest wins).
  always_comb begin
    win_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  // Pulses are gated by rst so that a reset drops them in the same cycle.
  assign accept   = !rst && (state_reg == ST_IDLE) && any_req;
  assign respond  = !rst && (state_reg == ST_RESP);
  assign cache_re = !rst && (state_reg == ST_ISSUE) && !we_reg;
  assign cache_we = !rst && (state_reg == ST_ISSUE) && we_reg;

  assign busy        = (state_reg != ST_IDLE);
  assign grant_id    = grant_reg;
  assign cache_addr  = addr_reg;
  assign cache_wdata = wdata_reg;
  assign rsp_rdata   = rdata_reg;
  assign rsp_hit     = hit_reg;
  assign rsp_err     = err_reg;
  assign err_count   = err_count_reg;

  // Next-state and datapath update for the transaction sequencer.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    cnt_next        = cnt_reg;
    rdata_next      = rdata_reg;
    hit_next        = hit_reg;
    err_next        = err_reg;
    err_count_next  = err_count_reg;

    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          grant_next = win_id;
          we_next    = req_we[win_id];
          addr_next  = addr_arr[win_id];
          wdata_next = wdata_arr[win_id];
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A cache_ready seen here belongs to nobody and is dropped.
        cnt_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cache_ready) begin
          rdata_next = cache_rdata;
          hit_next   = cache_hit;
          err_next   = 1'b0;
          state_next = ST_RESP;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          rdata_next = '0;
          hit_next   = 1'b0;
          err_next   = 1'b1;
          if (err_count_reg != 16'hFFFF) begin
            err_count_next = err_count_reg + 16'd1;
          end
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RESP: begin
        last_grant_next = grant_reg;
        state_next      = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns to IDLE with requester 0 first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= LAST_REQ;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cnt_reg        <= '0;
      rdata_reg      <= '0;
      hit_reg        <= 1'b0;
      err_reg        <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      cnt_reg        <= cnt_next;
      rdata_reg      <= rdata_next;
      hit_reg        <= hit_next;
      err_reg        <= err_next;
      err_count_reg  <= err_count_next;
    end
  end

endmodule

// File: tb/tb_l3_cache_port_arbiter.sv
// Directed testbench for l3_cache_port_arbiter: single read, timeout and
// error-count saturation, write strobe, round-robin wrap, mixed priority and
// reset in the middle of a transaction.
module tb_l3_cache_port_arbiter;

  localparam int NUM_REQ = 20;
  localparam int AW      = 32;
  localparam int DW      = 256;
  localparam int TMO     = 8;
  localparam int ID_W    = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_hit;
  logic                  rsp_err;
  logic [AW-1:0]         cache_addr;
  logic [DW-1:0]         cache_wdata;
  logic                  cache_we;
  logic                  cache_re;
  logic [DW-1:0]         cache_rdata;
  logic                  cache_ready;
  logic                  cache_hit;
  logic [ID_W-1:0]       grant_id;
  logic                  busy;
  logic [15:0]           err_count;

  l3_cache_port_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO),
    .ID_W       (ID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_hit     (rsp_hit),
    .rsp_err     (rsp_err),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_we    (cache_we),
    .cache_re    (cache_re),
    .cache_rdata (cache_rdata),
    .cache_ready (cache_ready),
    .cache_hit   (cache_hit),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_addr  [NUM_REQ];
  logic          exp_we    [NUM_REQ];
  logic [DW-1:0] exp_wdata [NUM_REQ];

  logic count_en = 1'b0;
  int   we_cycles;
  int   re_cycles;

  // Strobe counters for the write test window.
  always @(negedge clk) begin
    if (!count_en) begin
      we_cycles <= 0;
      re_cycles <= 0;
    end else begin
      if (cache_we) we_cycles <= we_cycles + 1;
      if (cache_re) re_cycles <= re_cycles + 1;
    end
  end

  // One line per completed transaction.
  always @(negedge clk) begin
    if (|rsp_valid) begin
      $display("txn t=%0t rsp_valid=%05h hit=%0b err=%0b err_count=%0d rdata=%h",
               $time, rsp_valid, rsp_hit, rsp_err, err_count, rsp_rdata);
    end
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k]            = 1'b1;
    req_we[k]               = we;
    req_addr[k*AW +: AW]    = a;
    req_wdata[k*DW +: DW]   = d;
    exp_addr[k]             = a;
    exp_we[k]               = we;
    exp_wdata[k]            = d;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid   = '0;
    cache_ready = 1'b0;
    step();
    step();
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    step();
  endtask

  // Entered at an IDLE cycle with requests already driven; leaves at the next IDLE cycle.
  task automatic serve(input int g, input bit keep, input logic [NUM_REQ-1:0] raise,
                       input bit ready_in_issue, input int delay,
                       input logic hit, input logic [DW-1:0] rdata);
    logic [NUM_REQ-1:0] oh;
    oh    = '0;
    oh[g] = 1'b1;
    #1;
    check_eq("req_ready", req_ready, oh);
    check_eq("idle_busy", busy, 0);
    step();  // ISSUE
    if (!keep) req_valid[g] = 1'b0;
    cache_ready = ready_in_issue;
    cache_hit   = 1'b1;
    cache_rdata = '1;
    #1;
    check_eq("issue_re", cache_re, !exp_we[g]);
    check_eq("issue_we", cache_we, exp_we[g]);
    check_eq("grant_id", grant_id, g);
    check_eq("cache_addr", cache_addr, exp_addr[g]);
    if (exp_we[g]) check_eq("cache_wdata", cache_wdata, exp_wdata[g]);
    step();  // first WAIT
    cache_ready = 1'b0;
    req_valid   = req_valid | raise;
    #1;
    check_eq("wait_strobes", {cache_re, cache_we}, 2'b00);
    check_eq("wait_rsp_valid", rsp_valid, 0);
    check_eq("wait_req_ready", req_ready, 0);
    for (int i = 0; i < delay; i++) step();
    cache_ready = 1'b1;
    cache_hit   = hit;
    cache_rdata = rdata;
    step();  // RESP
    cache_ready = 1'b0;
    cache_hit   = 1'b0;
    cache_rdata = '0;
    #1;
    check_eq("rsp_valid", rsp_valid, oh);
    check_eq("rsp_hit", rsp_hit, hit);
    check_eq("rsp_err", rsp_err, 0);
    if (!exp_we[g]) check_eq("rsp_rdata", rsp_rdata, rdata);
    check_eq("rsp_addr_hold", cache_addr, exp_addr[g]);
    step();  // IDLE
  endtask

  // Transaction that never sees cache_ready; response must land at ISSUE+TMO+1.
  task automatic run_timeout(input int g, input logic [15:0] cnt_before, input logic [15:0] cnt_after);
    logic [NUM_REQ-1:0] oh;
    oh    = '0;
    oh[g] = 1'b1;
    #1;
    check_eq("tmo_req_ready", req_ready, oh);
    step();  // ISSUE
    req_valid[g] = 1'b0;
    #1;
    check_eq("tmo_issue_re", cache_re, 1);
    for (int i = 1; i <= TMO; i++) begin
      step();
      #1;
      check_eq("tmo_wait_rsp_valid", rsp_valid, 0);
    end
    check_eq("tmo_err_count_before", err_count, cnt_before);
    step();  // RESP at ISSUE+TMO+1
    #1;
    check_eq("tmo_rsp_valid", rsp_valid, oh);
    check_eq("tmo_rsp_err", rsp_err, 1);
    check_eq("tmo_rsp_hit", rsp_hit, 0);
    check_eq("tmo_rsp_rdata", rsp_rdata, 0);
    check_eq("tmo_err_count_after", err_count, cnt_after);
    step();  // IDLE
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    logic [NUM_REQ-1:0] raise;
    logic [DW-1:0]      pat;

    rst         = 1'b1;
    req_valid   = '0;
    req_we      = '0;
    req_addr    = '0;
    req_wdata   = '0;
    cache_rdata = '0;
    cache_ready = 1'b0;
    cache_hit   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      exp_addr[k]  = '0;
      exp_we[k]    = 1'b0;
      exp_wdata[k] = '0;
    end

    // Reset state.
    step();
    step();
    #1;
    check_eq("reset_req_ready", req_ready, 0);
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_rsp_rdata", rsp_rdata, 0);
    check_eq("reset_rsp_flags", {rsp_hit, rsp_err}, 0);
    check_eq("reset_cache_addr", cache_addr, 0);
    check_eq("reset_cache_wdata", cache_wdata, 0);
    check_eq("reset_strobes", {cache_re, cache_we}, 0);
    check_eq("reset_grant_id", grant_id, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_err_count", err_count, 0);
    rst = 1'b0;
    step();

    // Single read from requester 3, ready in the first WAIT cycle.
    pat = {8{32'hA5A5A5A5}};
    set_req(3, 1'b0, 32'h100, '0);
    serve(3, 1'b0, '0, 1'b0, 0, 1'b1, pat);
    check_eq("read_idle_busy", busy, 0);

    // Timeout on requester 2; rdata must be forced to zero.
    set_req(2, 1'b0, 32'h200, '0);
    run_timeout(2, 16'd0, 16'd1);

    // Error counter saturation, starting one below the ceiling.
    force dut.err_count_reg = 16'hFFFE;
    step();
    step();
    release dut.err_count_reg;
    step();
    check_eq("sat_preload", err_count, 16'hFFFE);
    set_req(2, 1'b0, 32'h204, '0);
    run_timeout(2, 16'hFFFE, 16'hFFFF);
    set_req(2, 1'b0, 32'h208, '0);
    run_timeout(2, 16'hFFFF, 16'hFFFF);

    // Write from requester 16: exactly one cache_we cycle, no cache_re.
    count_en = 1'b1;
    set_req(16, 1'b1, 32'h40, {8{32'hDEADBEEF}});
    serve(16, 1'b0, '0, 1'b0, 1, 1'b1, '0);
    check_eq("write_we_cycles", we_cycles, 1);
    check_eq("write_re_cycles", re_cycles, 0);
    count_en = 1'b0;

    // Round-robin wrap with everyone requesting continuously.
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b0, AW'(k * 16), '0);
    for (int i = 0; i <= NUM_REQ; i++) begin
      pat = {8{32'h1000 + 32'(i)}};
      serve(i % NUM_REQ, 1'b1, '0, 1'b0, 0, 1'(i), pat);
    end
    req_valid = '0;

    // Mixed priority: last_grant=17, then 5 and 18, with 19 raised during 18's WAIT.
    do_reset();
    set_req(17, 1'b0, 32'h1700, '0);
    serve(17, 1'b0, '0, 1'b0, 0, 1'b1, {8{32'h17171717}});
    set_req(5, 1'b0, 32'h500, '0);
    set_req(19, 1'b1, 32'h1900, {8{32'h19191919}});
    req_valid[19] = 1'b0;
    set_req(18, 1'b0, 32'h1800, '0);
    raise     = '0;
    raise[19] = 1'b1;
    serve(18, 1'b0, raise, 1'b0, 0, 1'b0, {8{32'h18181818}});
    serve(19, 1'b0, '0, 1'b1, 0, 1'b1, '0);
    serve(5, 1'b0, '0, 1'b0, 2, 1'b1, {8{32'h05050505}});

    // Reset in WAIT, coincident with cache_ready: no response, last_grant back to 19.
    set_req(7, 1'b0, 32'h700, '0);
    #1;
    check_eq("mid_req_ready", req_ready, 20'h00080);
    step();  // ISSUE
    req_valid[7] = 1'b0;
    step();  // WAIT
    rst         = 1'b1;
    cache_ready = 1'b1;
    cache_rdata = {8{32'h77777777}};
    #1;
    check_eq("mid_wait_busy", busy, 1);
    step();
    rst         = 1'b0;
    cache_ready = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_rsp_valid", rsp_valid, 0);
    set_req(0, 1'b0, 32'h0, '0);
    set_req(18, 1'b0, 32'h1804, '0);
    serve(0, 1'b0, '0, 1'b0, 0, 1'b1, {8{32'h00C0FFEE}});
    serve(18, 1'b0, '0, 1'b0, 0, 1'b0, {8{32'h1804ABCD}});

    // Reset during ISSUE drops the strobe in the same cycle.
    set_req(4, 1'b0, 32'h400, '0);
    step();  // ISSUE
    req_valid[4] = 1'b0;
    #1;
    check_eq("issue_pre_rst_re", cache_re, 1);
    rst = 1'b1;
    #1;
    check_eq("issue_rst_re", cache_re, 0);
    step();
    rst = 1'b0;
    #1;
    check_eq("issue_rst_busy", busy, 0);
    check_eq("issue_rst_rsp_valid", rsp_valid, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
